// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core types: reorder-buffer tag width and the per-slot entry record.
package rv32i_types;

  localparam int LEN_ID = 3;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        isrd;
    logic [4:0]  rd;
    logic [31:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_flush_snapshot.sv
// Mispredict recovery rename snapshot: for every architectural register, find the
// youngest surviving ROB entry (head .. cdb_id) that still produces it.
module rob_flush_snapshot
  import rv32i_types::*;
#(
  parameter int len_id = LEN_ID,
  localparam int DEPTH = 2 ** len_id
) (
  input  logic [DEPTH-1:0]             slot_valid,
  input  logic [DEPTH-1:0]             slot_isrd,
  input  logic [DEPTH-1:0][4:0]        slot_rd,
  input  logic [len_id-1:0]            head,
  input  logic [len_id-1:0]            cdb_id,
  input  logic                         commit,
  output logic [31:0]                  flush_dep_rf_en,
  output logic [31:0][len_id-1:0]      flush_dep_rf
);

  logic [len_id-1:0] span;
  logic [len_id-1:0] slot;

  assign span = cdb_id - head;

  // Walk oldest to youngest so the last match written is the youngest producer.
  always_comb begin
    flush_dep_rf_en = '0;
    flush_dep_rf    = '0;
    slot            = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head + len_id'(k);
      if ((len_id'(k) <= span) && !((k == 0) && commit) &&
          slot_valid[slot] && slot_isrd[slot] && (slot_rd[slot] != 5'd0)) begin
        flush_dep_rf_en[slot_rd[slot]] = 1'b1;
        flush_dep_rf[slot_rd[slot]]    = slot;
      end
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: tag allocation at issue, CDB capture, in-order single retire,
// and mispredict squash with register rename snapshot.
module rob_commit_unit
  import rv32i_types::*;
#(
  parameter int len_id = LEN_ID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_req,
  input  logic                    issue_isrd,
  input  logic [4:0]              issue_rd,
  output logic [len_id-1:0]       rob_id,
  output logic                    rob_full,
  input  logic                    cdb_valid,
  input  logic [len_id-1:0]       cdb_id,
  input  logic [31:0]             cdb_data,
  input  logic                    cdb_mispred,
  input  logic [31:0]             cdb_target,
  input  logic [len_id-1:0]       rob_sr1_id,
  output logic                    rob_sr1_rdy,
  output logic [31:0]             rob_sr1_val,
  input  logic [len_id-1:0]       rob_sr2_id,
  output logic                    rob_sr2_rdy,
  output logic [31:0]             rob_sr2_val,
  output logic                    commit_rf_en,
  output logic [4:0]              commit_rd,
  output logic [31:0]             commit_data,
  output logic                    flush_rf_en,
  output logic [31:0]             flush_dep_rf_en,
  output logic [31:0][len_id-1:0] flush_dep_rf,
  output logic                    flush_pc_en,
  output logic [31:0]             flush_pc
);

  localparam int DEPTH = 2 ** len_id;
  localparam logic [len_id:0] PTR_ONE = 1;

  logic [len_id:0]   head_q, head_d, tail_q, tail_d;
  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];

  logic [len_id-1:0] head_idx, tail_idx, flush_span;
  logic              full, cdb_hit, flush, commit, issue;
  logic [DEPTH-1:0]      slot_valid, slot_isrd;
  logic [DEPTH-1:0][4:0] slot_rd;
  logic [31:0]             snap_en;
  logic [31:0][len_id-1:0] snap_tag;

  assign head_idx   = head_q[len_id-1:0];
  assign tail_idx   = tail_q[len_id-1:0];
  assign full       = (head_idx == tail_idx) && (head_q[len_id] != tail_q[len_id]);
  assign cdb_hit    = cdb_valid && entries_q[cdb_id].valid;
  assign flush      = !rst && cdb_hit && cdb_mispred;
  assign commit     = !rst && entries_q[head_idx].valid && entries_q[head_idx].done;
  assign issue      = !rst && issue_req && !full && !flush;
  assign flush_span = cdb_id - head_idx;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_valid[i] = entries_q[i].valid;
      slot_isrd[i]  = entries_q[i].isrd;
      slot_rd[i]    = entries_q[i].rd;
    end
  end

  rob_flush_snapshot #(.len_id(len_id)) u_snapshot (
    .slot_valid      (slot_valid),
    .slot_isrd       (slot_isrd),
    .slot_rd         (slot_rd),
    .head            (head_idx),
    .cdb_id          (cdb_id),
    .commit          (commit),
    .flush_dep_rf_en (snap_en),
    .flush_dep_rf    (snap_tag)
  );

  always_comb begin
    rob_id          = rst ? '0 : tail_idx;
    rob_full        = !rst && full;
    commit_rf_en    = commit;
    commit_rd       = entries_q[head_idx].isrd ? entries_q[head_idx].rd : 5'd0;
    commit_data     = entries_q[head_idx].data;
    flush_rf_en     = flush;
    flush_pc_en     = flush;
    flush_pc        = cdb_target;
    flush_dep_rf_en = flush ? snap_en : '0;
    flush_dep_rf    = flush ? snap_tag : '0;
    rob_sr1_rdy     = !rst && ((entries_q[rob_sr1_id].valid && entries_q[rob_sr1_id].done) ||
                               (cdb_valid && (cdb_id == rob_sr1_id)));
    rob_sr1_val     = (cdb_valid && (cdb_id == rob_sr1_id)) ? cdb_data : entries_q[rob_sr1_id].data;
    rob_sr2_rdy     = !rst && ((entries_q[rob_sr2_id].valid && entries_q[rob_sr2_id].done) ||
                               (cdb_valid && (cdb_id == rob_sr2_id)));
    rob_sr2_val     = (cdb_valid && (cdb_id == rob_sr2_id)) ? cdb_data : entries_q[rob_sr2_id].data;
  end

  // Order matters: CDB capture, then retire clears head, then squash, then allocate.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (cdb_hit) begin
      entries_d[cdb_id].done = 1'b1;
      entries_d[cdb_id].data = cdb_data;
    end
    if (commit) begin
      entries_d[head_idx].valid = 1'b0;
      entries_d[head_idx].done  = 1'b0;
      head_d = head_q + PTR_ONE;
    end
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((len_id'(i) - head_idx) > flush_span) begin
          entries_d[i].valid = 1'b0;
          entries_d[i].done  = 1'b0;
        end
      end
      tail_d = head_q + {1'b0, flush_span} + PTR_ONE;
    end
    if (issue) begin
      entries_d[tail_idx].valid = 1'b1;
      entries_d[tail_idx].done  = 1'b0;
      entries_d[tail_idx].isrd  = issue_isrd;
      entries_d[tail_idx].rd    = issue_rd;
      entries_d[tail_idx].data  = '0;
      tail_d = tail_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed scenarios plus randomized traffic
// checked against an in-order queue model of the reorder buffer.
module tb_rob_commit_unit;

  localparam int LID   = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic issue_req, issue_isrd;
  logic [4:0] issue_rd;
  logic [LID-1:0] rob_id;
  logic rob_full;
  logic cdb_valid, cdb_mispred;
  logic [LID-1:0] cdb_id;
  logic [31:0] cdb_data, cdb_target;
  logic [LID-1:0] rob_sr1_id, rob_sr2_id;
  logic rob_sr1_rdy, rob_sr2_rdy;
  logic [31:0] rob_sr1_val, rob_sr2_val;
  logic commit_rf_en;
  logic [4:0] commit_rd;
  logic [31:0] commit_data;
  logic flush_rf_en, flush_pc_en;
  logic [31:0] flush_dep_rf_en;
  logic [31:0][LID-1:0] flush_dep_rf;
  logic [31:0] flush_pc;

  always #5 clk = ~clk;

  rob_commit_unit #(.len_id(LID)) dut (
    .clk(clk), .rst(rst),
    .issue_req(issue_req), .issue_isrd(issue_isrd), .issue_rd(issue_rd),
    .rob_id(rob_id), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
    .rob_sr1_id(rob_sr1_id), .rob_sr1_rdy(rob_sr1_rdy), .rob_sr1_val(rob_sr1_val),
    .rob_sr2_id(rob_sr2_id), .rob_sr2_rdy(rob_sr2_rdy), .rob_sr2_val(rob_sr2_val),
    .commit_rf_en(commit_rf_en), .commit_rd(commit_rd), .commit_data(commit_data),
    .flush_rf_en(flush_rf_en), .flush_dep_rf_en(flush_dep_rf_en), .flush_dep_rf(flush_dep_rf),
    .flush_pc_en(flush_pc_en), .flush_pc(flush_pc)
  );

  // Reference model: program-ordered list of in-flight instructions.
  typedef struct {
    int        tag;
    bit        isrd;
    bit [4:0]  rd;
    bit        done;
    bit [31:0] data;
  } ment_t;

  ment_t mq[$];
  int next_tag;
  int tests_run;
  int tests_failed;

  function automatic int m_find(input int tag);
    for (int i = 0; i < mq.size(); i++) if (mq[i].tag == tag) return i;
    return -1;
  endfunction

  function automatic bit m_full();
    return mq.size() == DEPTH;
  endfunction

  function automatic bit m_commit();
    return !rst && (mq.size() > 0) && mq[0].done;
  endfunction

  function automatic bit m_flush();
    return !rst && cdb_valid && cdb_mispred && (m_find(int'(cdb_id)) >= 0);
  endfunction

  function automatic bit m_issue();
    return !rst && issue_req && !m_full() && !m_flush();
  endfunction

  task automatic m_snapshot(output logic [31:0] en, output logic [31:0][LID-1:0] tg);
    int fi;
    en = '0;
    tg = '0;
    if (m_flush()) begin
      fi = m_find(int'(cdb_id));
      for (int i = (m_commit() ? 1 : 0); i <= fi; i++) begin
        if (mq[i].isrd && (mq[i].rd != 5'd0)) begin
          en[mq[i].rd] = 1'b1;
          tg[mq[i].rd] = LID'(mq[i].tag);
        end
      end
    end
  endtask

  task automatic m_lookup(input logic [LID-1:0] id, output logic rdy, output logic [31:0] val);
    int idx;
    rdy = 1'b0;
    val = '0;
    if (!rst) begin
      if (cdb_valid && (cdb_id == id)) begin
        rdy = 1'b1;
        val = cdb_data;
      end else begin
        idx = m_find(int'(id));
        if ((idx >= 0) && mq[idx].done) begin
          rdy = 1'b1;
          val = mq[idx].data;
        end
      end
    end
  endtask

  // Advance one clock and apply the same transaction to the model.
  task automatic tick();
    bit c, f, is;
    int fi;
    ment_t e;
    c  = m_commit();
    f  = m_flush();
    is = m_issue();
    fi = m_find(int'(cdb_id));
    @(posedge clk);
    if (rst) begin
      mq.delete();
      next_tag = 0;
    end else begin
      if (cdb_valid && (fi >= 0)) begin
        e = mq[fi]; e.done = 1'b1; e.data = cdb_data; mq[fi] = e;
      end
      if (c) begin
        void'(mq.pop_front());
        fi--;
      end
      if (f) begin
        while (mq.size() > fi + 1) void'(mq.pop_back());
        next_tag = (int'(cdb_id) + 1) % DEPTH;
      end
      if (is) begin
        e.tag = next_tag; e.isrd = issue_isrd; e.rd = issue_rd; e.done = 1'b0; e.data = '0;
        mq.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    issue_req = 0; issue_isrd = 0; issue_rd = '0;
    cdb_valid = 0; cdb_id = '0; cdb_data = '0; cdb_mispred = 0; cdb_target = '0;
    rob_sr1_id = '0; rob_sr2_id = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic issue(input bit isrd, input logic [4:0] rd);
    idle();
    issue_req = 1; issue_isrd = isrd; issue_rd = rd;
    #1;
    tick();
  endtask

  task automatic drain();
    int budget;
    budget = 64;
    while ((mq.size() > 0) && (budget > 0)) begin
      idle();
      foreach (mq[i]) begin
        if (!mq[i].done && !cdb_valid) begin
          cdb_valid = 1; cdb_id = LID'(mq[i].tag); cdb_data = $urandom;
        end
      end
      #1;
      tick();
      budget--;
    end
    if (mq.size() > 0) begin
      tests_run++; tests_failed++;
      $display("FAIL drain_timeout: %0d entries left, required 0", mq.size());
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    issue_req = 1; issue_isrd = 1; issue_rd = 5'd3;
    cdb_valid = 1; cdb_id = 3'd2; cdb_mispred = 1; rob_sr1_id = 3'd2; rob_sr2_id = 3'd2;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++; if (rob_full !== 1'b0) begin tests_failed++; $display("FAIL rst_full: got %b required 0", rob_full); end
      tests_run++; if (rob_id !== 3'd0) begin tests_failed++; $display("FAIL rst_rob_id: got %0d required 0", rob_id); end
      tests_run++; if (commit_rf_en !== 1'b0) begin tests_failed++; $display("FAIL rst_commit: got %b required 0", commit_rf_en); end
      tests_run++; if ({flush_rf_en, flush_pc_en} !== 2'b00) begin tests_failed++; $display("FAIL rst_flush: got %b%b required 00", flush_rf_en, flush_pc_en); end
      tests_run++; if (flush_dep_rf_en !== 32'd0) begin tests_failed++; $display("FAIL rst_dep_en: got %h required 0", flush_dep_rf_en); end
      tests_run++; if ({rob_sr1_rdy, rob_sr2_rdy} !== 2'b00) begin tests_failed++; $display("FAIL rst_rdy: got %b%b required 00", rob_sr1_rdy, rob_sr2_rdy); end
      tick();
    end
    rst = 0;
    idle();
    #1;
    tests_run++; if (rob_id !== 3'd0) begin tests_failed++; $display("FAIL post_rst_rob_id: got %0d required 0", rob_id); end
    tests_run++; if ({rob_full, commit_rf_en} !== 2'b00) begin tests_failed++; $display("FAIL post_rst_state: got %b%b required 00", rob_full, commit_rf_en); end
  endtask

  task automatic test_issue_commit();
    do_reset();
    issue_req = 1; issue_isrd = 1; issue_rd = 5'd5;
    #1;
    tests_run++; if (rob_id !== 3'd0) begin tests_failed++; $display("FAIL ic_rob_id: got %0d required 0", rob_id); end
    tick();
    idle();
    cdb_valid = 1; cdb_id = 3'd0; cdb_data = 32'h11;
    #1;
    tests_run++; if (commit_rf_en !== 1'b0) begin tests_failed++; $display("FAIL ic_no_bypass: got %b required 0", commit_rf_en); end
    tick();
    idle();
    #1;
    tests_run++; if (commit_rf_en !== 1'b1) begin tests_failed++; $display("FAIL ic_commit_en: got %b required 1", commit_rf_en); end
    tests_run++; if (commit_rd !== 5'd5) begin tests_failed++; $display("FAIL ic_commit_rd: got %0d required 5", commit_rd); end
    tests_run++; if (commit_data !== 32'h11) begin tests_failed++; $display("FAIL ic_commit_data: got %h required 11", commit_data); end
    tick();
    drain();
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      issue_req = 1; issue_isrd = 1; issue_rd = 5'(i + 8);
      #1;
      tests_run++; if (rob_id !== LID'(i)) begin tests_failed++; $display("FAIL fw_rob_id: got %0d required %0d", rob_id, i); end
      tests_run++; if (rob_full !== 1'b0) begin tests_failed++; $display("FAIL fw_not_full: got %b required 0 at %0d", rob_full, i); end
      tick();
    end
    issue_req = 1; issue_rd = 5'd20;
    #1;
    tests_run++; if (rob_full !== 1'b1) begin tests_failed++; $display("FAIL fw_full: got %b required 1", rob_full); end
    tick();
    idle();
    cdb_valid = 1; cdb_id = 3'd0; cdb_data = 32'h55;
    #1;
    tests_run++; if ((rob_full !== 1'b1) || (rob_id !== 3'd0)) begin tests_failed++; $display("FAIL fw_ignored: got full=%b id=%0d required full=1 id=0", rob_full, rob_id); end
    tick();
    idle();
    issue_req = 1; issue_isrd = 1; issue_rd = 5'd21;
    #1;
    tests_run++; if ({commit_rf_en, rob_full} !== 2'b11) begin tests_failed++; $display("FAIL fw_commit_full: got %b%b required 11", commit_rf_en, rob_full); end
    tick();
    #1;
    tests_run++; if ((rob_full !== 1'b0) || (rob_id !== 3'd0)) begin tests_failed++; $display("FAIL fw_wrap: got full=%b id=%0d required full=0 id=0", rob_full, rob_id); end
    tick();
    idle();
    #1;
    tests_run++; if (rob_full !== 1'b1) begin tests_failed++; $display("FAIL fw_refull: got %b required 1", rob_full); end
    drain();
  endtask

  task automatic test_out_of_order();
    logic [31:0] d [3];
    d[0] = 32'h1001; d[1] = 32'h2002; d[2] = 32'h3003;
    do_reset();
    for (int i = 0; i < 3; i++) issue(1'b1, 5'(i + 1));
    for (int i = 2; i >= 0; i--) begin
      idle();
      cdb_valid = 1; cdb_id = LID'(i); cdb_data = d[i];
      #1;
      tests_run++; if (commit_rf_en !== 1'b0) begin tests_failed++; $display("FAIL ooo_early_commit: got %b required 0 (cdb id%0d)", commit_rf_en, i); end
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ((commit_rf_en !== 1'b1) || (commit_rd !== 5'(i + 1)) || (commit_data !== d[i])) begin
        tests_failed++;
        $display("FAIL ooo_commit%0d: got en=%b rd=%0d data=%h required en=1 rd=%0d data=%h", i, commit_rf_en, commit_rd, commit_data, i + 1, d[i]);
      end
      tick();
    end
    #1;
    tests_run++; if (commit_rf_en !== 1'b0) begin tests_failed++; $display("FAIL ooo_drained: got %b required 0", commit_rf_en); end
  endtask

  task automatic test_mispredict_flush();
    do_reset();
    issue(1'b1, 5'd4);
    issue(1'b1, 5'd4);
    issue(1'b0, 5'd0);
    issue(1'b1, 5'd4);
    issue(1'b1, 5'd6);
    idle();
    cdb_valid = 1; cdb_id = 3'd2; cdb_mispred = 1; cdb_target = 32'h80;
    issue_req = 1; issue_isrd = 1; issue_rd = 5'd9;
    #1;
    tests_run++; if ({flush_rf_en, flush_pc_en} !== 2'b11) begin tests_failed++; $display("FAIL mp_flush_en: got %b%b required 11", flush_rf_en, flush_pc_en); end
    tests_run++; if (flush_dep_rf_en[4] !== 1'b1) begin tests_failed++; $display("FAIL mp_dep_en4: got %b required 1", flush_dep_rf_en[4]); end
    tests_run++; if (flush_dep_rf[4] !== 3'd1) begin tests_failed++; $display("FAIL mp_dep4: got %0d required 1", flush_dep_rf[4]); end
    tests_run++; if (flush_dep_rf_en[6] !== 1'b0) begin tests_failed++; $display("FAIL mp_dep_en6: got %b required 0", flush_dep_rf_en[6]); end
    tests_run++; if (flush_pc !== 32'h80) begin tests_failed++; $display("FAIL mp_pc: got %h required 80", flush_pc); end
    tick();
    idle();
    #1;
    tests_run++; if (rob_id !== 3'd3) begin tests_failed++; $display("FAIL mp_next_id: got %0d required 3", rob_id); end
    tests_run++; if (flush_rf_en !== 1'b0) begin tests_failed++; $display("FAIL mp_one_shot: got %b required 0", flush_rf_en); end
    drain();
  endtask

  task automatic test_commit_with_flush();
    do_reset();
    issue(1'b1, 5'd7);
    idle();
    cdb_valid = 1; cdb_id = 3'd0; cdb_data = 32'h77;
    #1;
    tick();
    idle();
    cdb_valid = 1; cdb_id = 3'd0; cdb_data = 32'h77; cdb_mispred = 1; cdb_target = 32'h100;
    #1;
    tests_run++; if ((commit_rf_en !== 1'b1) || (commit_rd !== 5'd7)) begin tests_failed++; $display("FAIL cf_commit: got en=%b rd=%0d required en=1 rd=7", commit_rf_en, commit_rd); end
    tests_run++; if (flush_rf_en !== 1'b1) begin tests_failed++; $display("FAIL cf_flush: got %b required 1", flush_rf_en); end
    tests_run++; if (flush_dep_rf_en !== 32'd0) begin tests_failed++; $display("FAIL cf_dep_en: got %h required 0", flush_dep_rf_en); end
    tick();
    idle();
    #1;
    tests_run++; if ({commit_rf_en, rob_full} !== 2'b00 || rob_id !== 3'd1) begin tests_failed++; $display("FAIL cf_empty: got commit=%b full=%b id=%0d required 0 0 1", commit_rf_en, rob_full, rob_id); end
    tick();
    #1;
    tests_run++; if (commit_rf_en !== 1'b0) begin tests_failed++; $display("FAIL cf_stays_empty: got %b required 0", commit_rf_en); end
  endtask

  task automatic test_lookup_and_reset();
    do_reset();
    for (int i = 0; i < 3; i++) issue(1'b1, 5'(i + 10));
    idle();
    cdb_valid = 1; cdb_id = 3'd2; cdb_data = 32'hAB; rob_sr1_id = 3'd2; rob_sr2_id = 3'd0;
    #1;
    tests_run++; if ((rob_sr1_rdy !== 1'b1) || (rob_sr1_val !== 32'hAB)) begin tests_failed++; $display("FAIL lk_bypass: got rdy=%b val=%h required rdy=1 val=ab", rob_sr1_rdy, rob_sr1_val); end
    tests_run++; if (rob_sr2_rdy !== 1'b0) begin tests_failed++; $display("FAIL lk_not_ready: got %b required 0", rob_sr2_rdy); end
    tick();
    idle();
    rob_sr2_id = 3'd2; cdb_valid = 1; cdb_id = 3'd0; cdb_data = 32'hCD;
    #1;
    tests_run++; if ((rob_sr2_rdy !== 1'b1) || (rob_sr2_val !== 32'hAB)) begin tests_failed++; $display("FAIL lk_stored: got rdy=%b val=%h required rdy=1 val=ab", rob_sr2_rdy, rob_sr2_val); end
    tick();
    idle();
    rst = 1;
    issue_req = 1; issue_isrd = 1; issue_rd = 5'd9;
    cdb_valid = 1; cdb_id = 3'd1; cdb_mispred = 1; rob_sr1_id = 3'd0; rob_sr2_id = 3'd2;
    #1;
    tests_run++; if ({commit_rf_en, flush_rf_en, flush_pc_en} !== 3'b000) begin tests_failed++; $display("FAIL lk_rst_ctrl: got %b%b%b required 000", commit_rf_en, flush_rf_en, flush_pc_en); end
    tests_run++; if ({rob_full, rob_sr1_rdy, rob_sr2_rdy} !== 3'b000 || rob_id !== 3'd0 || flush_dep_rf_en !== 32'd0) begin tests_failed++; $display("FAIL lk_rst_out: got full=%b rdy=%b%b id=%0d dep=%h required zeros", rob_full, rob_sr1_rdy, rob_sr2_rdy, rob_id, flush_dep_rf_en); end
    tick();
    rst = 0;
    idle();
    issue_req = 1; issue_isrd = 1; issue_rd = 5'd9;
    #1;
    tests_run++; if ((rob_id !== 3'd0) || (commit_rf_en !== 1'b0)) begin tests_failed++; $display("FAIL lk_after_rst: got id=%0d commit=%b required id=0 commit=0", rob_id, commit_rf_en); end
    tick();
    drain();
  endtask

  task automatic test_random();
    logic [31:0] e_en;
    logic [31:0][LID-1:0] e_tag;
    logic e_rdy1, e_rdy2;
    logic [31:0] e_val1, e_val2;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      issue_req = ($urandom_range(0, 9) < 6);
      issue_isrd = ($urandom_range(0, 3) != 0);
      issue_rd = 5'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        cdb_valid = 1;
        if ((mq.size() > 0) && ($urandom_range(0, 3) != 0)) cdb_id = LID'(mq[$urandom_range(0, mq.size() - 1)].tag);
        else cdb_id = LID'($urandom);
        cdb_mispred = ($urandom_range(0, 9) == 0);
        cdb_data = $urandom;
        cdb_target = $urandom;
      end
      rob_sr1_id = LID'($urandom);
      rob_sr2_id = (mq.size() > 0) ? LID'(mq[$urandom_range(0, mq.size() - 1)].tag) : LID'($urandom);
      #1;
      m_snapshot(e_en, e_tag);
      m_lookup(rob_sr1_id, e_rdy1, e_val1);
      m_lookup(rob_sr2_id, e_rdy2, e_val2);
      tests_run++; if (rob_full !== (!rst && m_full())) begin tests_failed++; $display("FAIL rnd_full[%0d]: got %b required %b", n, rob_full, !rst && m_full()); end
      tests_run++; if (rob_id !== (rst ? 3'd0 : LID'(next_tag))) begin tests_failed++; $display("FAIL rnd_rob_id[%0d]: got %0d required %0d", n, rob_id, rst ? 0 : next_tag); end
      tests_run++; if (commit_rf_en !== m_commit()) begin tests_failed++; $display("FAIL rnd_commit_en[%0d]: got %b required %b", n, commit_rf_en, m_commit()); end
      if (m_commit()) begin
        tests_run++;
        if ((commit_rd !== (mq[0].isrd ? mq[0].rd : 5'd0)) || (commit_data !== mq[0].data)) begin
          tests_failed++;
          $display("FAIL rnd_commit_val[%0d]: got rd=%0d data=%h required rd=%0d data=%h", n, commit_rd, commit_data, mq[0].isrd ? mq[0].rd : 5'd0, mq[0].data);
        end
      end
      tests_run++; if ({flush_rf_en, flush_pc_en} !== {2{m_flush()}}) begin tests_failed++; $display("FAIL rnd_flush[%0d]: got %b%b required %b", n, flush_rf_en, flush_pc_en, m_flush()); end
      if (m_flush()) begin
        tests_run++; if (flush_pc !== cdb_target) begin tests_failed++; $display("FAIL rnd_flush_pc[%0d]: got %h required %h", n, flush_pc, cdb_target); end
      end
      tests_run++; if (flush_dep_rf_en !== e_en) begin tests_failed++; $display("FAIL rnd_dep_en[%0d]: got %h required %h", n, flush_dep_rf_en, e_en); end
      tests_run++; if (flush_dep_rf !== e_tag) begin tests_failed++; $display("FAIL rnd_dep_tag[%0d]: got %h required %h", n, flush_dep_rf, e_tag); end
      tests_run++; if ((rob_sr1_rdy !== e_rdy1) || (e_rdy1 && (rob_sr1_val !== e_val1))) begin tests_failed++; $display("FAIL rnd_sr1[%0d]: got rdy=%b val=%h required rdy=%b val=%h", n, rob_sr1_rdy, rob_sr1_val, e_rdy1, e_val1); end
      tests_run++; if ((rob_sr2_rdy !== e_rdy2) || (e_rdy2 && (rob_sr2_val !== e_val2))) begin tests_failed++; $display("FAIL rnd_sr2[%0d]: got rdy=%b val=%h required rdy=%b val=%h", n, rob_sr2_rdy, rob_sr2_val, e_rdy2, e_val2); end
      tick();
    end
    rst = 0;
    drain();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    next_tag = 0;
    rst = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_issue_commit();
    test_full_wrap();
    test_out_of_order();
    test_mispredict_flush();
    test_commit_with_flush();
    test_lookup_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
